// File: rtl/sae_char_sequencer.sv
// sae_char_sequencer: upstream feeder for the character encryption core.
// Plaintext bytes are queued in a small FIFO. Each byte is issued to the core
// as one encrypt request. The result, or a timeout, is returned in input order
// on a valid/ready stream.
`timescale 1ns/1ps
module sae_char_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_load,
  input  logic [7:0]                   key_in,
  input  logic                         ptxt_valid,
  input  logic [7:0]                   ptxt_data,
  output logic                         ptxt_ready,
  output logic                         ctxt_valid,
  output logic [7:0]                   ctxt_data,
  output logic                         ctxt_err,
  input  logic                         ctxt_ready,
  output logic [1:0]                   core_mode,
  output logic [7:0]                   core_plaintext,
  output logic [7:0]                   core_public_key,
  input  logic [7:0]                   core_char_ciphertext,
  input  logic                         core_c_ready,
  input  logic                         core_err_invalid_ptxt,
  output logic                         timeout_err,
  input  logic                         clr_err,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_ENC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    mode_r, mode_nxt_s;
  logic [7:0]    ptxt_r, ptxt_nxt_s;
  logic [TW-1:0] tmr_r, tmr_nxt_s;
  logic [7:0]    key_r;

  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          ctxt_valid_r, ctxt_err_r, timeout_err_r;
  logic [7:0]    ctxt_data_r;

  logic          push_s, pop_s, cap_s, cap_err_s, tmo_s, out_done_s;
  logic [7:0]    cap_data_s;

  // ready must drop while reset is held, so it is gated by rst directly
  assign ptxt_ready      = ~rst & (count_r < CW'(FIFO_DEPTH));
  assign push_s          = ptxt_valid & ptxt_ready;
  assign pop_s           = cap_s;

  assign core_mode       = mode_r;
  assign core_plaintext  = ptxt_r;
  assign core_public_key = key_r;
  assign ctxt_valid      = ctxt_valid_r;
  assign ctxt_data       = ctxt_data_r;
  assign ctxt_err        = ctxt_err_r;
  assign timeout_err     = timeout_err_r;
  assign fifo_count      = count_r;
  assign busy            = (state_r != ST_IDLE);

  // Next-state, request and result-capture decode for the request FSM
  always_comb begin
    state_nxt_s = state_r;
    mode_nxt_s  = mode_r;
    ptxt_nxt_s  = ptxt_r;
    tmr_nxt_s   = tmr_r;
    cap_s       = 1'b0;
    cap_data_s  = 8'h00;
    cap_err_s   = 1'b0;
    tmo_s       = 1'b0;
    out_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          ptxt_nxt_s  = mem_r[rd_ptr_r];
          mode_nxt_s  = MODE_ENC;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmr_nxt_s   = {TW{1'b0}};
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_nxt_s = tmr_r + TW'(1'b1);
        if (core_c_ready || core_err_invalid_ptxt) begin
          // the error flag rides along with whatever data the core presents
          cap_s       = 1'b1;
          cap_data_s  = core_char_ciphertext;
          cap_err_s   = core_err_invalid_ptxt;
          mode_nxt_s  = MODE_IDLE;
          state_nxt_s = ST_OUT;
        end else if (tmr_r == TW'(TIMEOUT_CYCLES - 1)) begin
          cap_s       = 1'b1;
          cap_data_s  = 8'h00;
          cap_err_s   = 1'b1;
          tmo_s       = 1'b1;
          mode_nxt_s  = MODE_IDLE;
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (ctxt_valid_r && ctxt_ready) begin
          out_done_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        mode_nxt_s  = MODE_IDLE;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state plus the request registers presented to the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_IDLE;
      ptxt_r  <= 8'h00;
      tmr_r   <= {TW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      mode_r  <= mode_nxt_s;
      ptxt_r  <= ptxt_nxt_s;
      tmr_r   <= tmr_nxt_s;
    end
  end

  // Key register; only replaced when nothing is queued or in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r <= 8'h00;
    end else if (key_load && (state_r == ST_IDLE) && (count_r == {CW{1'b0}})) begin
      key_r <= key_in;
    end
  end

  // FIFO storage; entries are only read when qualified by count_r
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= ptxt_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Result stream registers and the sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctxt_valid_r  <= 1'b0;
      ctxt_data_r   <= 8'h00;
      ctxt_err_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (cap_s) begin
        ctxt_valid_r <= 1'b1;
        ctxt_data_r  <= cap_data_s;
        ctxt_err_r   <= cap_err_s;
      end else if (out_done_s) begin
        ctxt_valid_r <= 1'b0;
      end
      // a timeout in the same cycle as a clear keeps the flag set
      if (tmo_s) begin
        timeout_err_r <= 1'b1;
      end else if (clr_err) begin
        timeout_err_r <= 1'b0;
      end
    end
  end

endmodule
